// File: rtl/oclib_ready_valid_to_async_req_ack_if.sv
// Handshake bundle for oclib_ready_valid_to_async_req_ack.
// The ready/valid producer side and the four-phase receiver side share one interface.
// "slave" is the bridge's own view of the bundle.
// "master" is the environment's view: it drives the producer and the receiver acknowledge.
interface oclib_ready_valid_to_async_req_ack_if #(
  parameter int Width = 8
);
  logic [Width-1:0] inData;
  logic             inValid;
  logic             inReady;
  logic [Width-1:0] outData;
  logic             outReq;
  logic             outAck;
  logic             outBusy;

  modport master (
    output inData, inValid, outAck,
    input  inReady, outData, outReq, outBusy
  );

  modport slave (
    input  inData, inValid, outAck,
    output inReady, outData, outReq, outBusy
  );
endinterface

// File: rtl/oclib_ready_valid_to_async_req_ack.sv
// Bridge from a synchronous ready/valid producer to an asynchronous four-phase
// req/ack receiver. One word is in flight at a time.
//
// outData is registered at accept and is held until the next accept.
// outReq rises SetupCycles+1 cycles after accept.
// The acknowledge is only used after it passes through a SyncCycles-deep synchronizer.
module oclib_ready_valid_to_async_req_ack #(
  parameter int Width       = 8,
  parameter int SyncCycles  = 3,   // legal range 2..8
  parameter int SetupCycles = 1    // legal range 0..15
) (
  input logic                                 clock,
  input logic                                 reset,   // synchronous, active low
  oclib_ready_valid_to_async_req_ack_if.slave bus
);

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SETUP       = 2'd1;
  localparam logic [1:0] WAIT_ACK_HI = 2'd2;
  localparam logic [1:0] WAIT_ACK_LO = 2'd3;

  localparam bit         HasSetup  = (SetupCycles > 0);
  localparam logic [3:0] SetupLoad = (SetupCycles > 0) ? 4'(SetupCycles - 1) : 4'd0;

  logic [SyncCycles-1:0] ack_sync_q, ack_sync_d;
  logic                  ack_sync;
  logic [1:0]            state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic                  out_req_q, out_req_d;
  logic [Width-1:0]      out_data_q, out_data_d;
  logic                  out_busy_q, out_busy_d;
  logic                  accept;

  // Shift the raw acknowledge into the synchronizer chain; only the last stage is used.
  always_comb begin
    ack_sync_d = {ack_sync_q[SyncCycles-2:0], bus.outAck};
  end

  assign ack_sync = ack_sync_q[SyncCycles-1];

  // Ready comes from registered state and the reset pin only, never from inValid.
  assign bus.inReady = reset && (state_q == IDLE);
  assign accept      = bus.inValid && bus.inReady;

  // Handshake sequencing: accept, setup hold, request, wait for ack high then low.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    state_d    = state_q;
    count_d    = count_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          out_data_d = bus.inData;
          // A stale ack seen at accept time parks the word in SETUP with an
          // expired counter, so the request waits there until the ack drops.
          if (HasSetup || ack_sync) begin
            state_d = SETUP;
            count_d = SetupLoad;
          end else begin
            state_d   = WAIT_ACK_HI;
            out_req_d = 1'b1;
          end
        end
      end
      SETUP: begin
        if (count_q != 4'd0) begin
          count_d = count_q - 4'd1;
        end else if (!ack_sync) begin
          state_d   = WAIT_ACK_HI;
          out_req_d = 1'b1;
        end
      end
      WAIT_ACK_HI: begin
        if (ack_sync) begin
          out_req_d = 1'b0;
          state_d   = WAIT_ACK_LO;
        end
      end
      WAIT_ACK_LO: begin
        if (!ack_sync) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        out_req_d = 1'b0;
      end
    endcase

    out_busy_d = (state_d != IDLE);
  end

  // State, synchronizer and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: flops are written with non-blocking assignments so that each one
    // samples the values from before the edge, regardless of statement order.
    if (!reset) begin
      // NOTE: the payload register is cleared on reset as well, because the
      // receiver can observe outData directly.
      ack_sync_q <= '0;
      state_q    <= IDLE;
      count_q    <= 4'd0;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      out_busy_q <= 1'b0;
    end else begin
      ack_sync_q <= ack_sync_d;
      state_q    <= state_d;
      count_q    <= count_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      out_busy_q <= out_busy_d;
    end
  end

  assign bus.outData = out_data_q;
  assign bus.outReq  = out_req_q;
  assign bus.outBusy = out_busy_q;

endmodule

// File: tb/tb_oclib_ready_valid_to_async_req_ack.sv
// Self-checking bench for oclib_ready_valid_to_async_req_ack.
//
// A negedge monitor keeps a behavioural model of the transfer rules:
// - a queue of accepted words,
// - the last accepted payload,
// - whether a four-phase cycle is open.
// The monitor compares the DUT against that model whenever it presents a request.
//
// A receiver process plays the async side. It either follows outReq after
// random delays, or it follows a manual acknowledge driven by directed tests.
module tb_oclib_ready_valid_to_async_req_ack;

  localparam int Width       = 8;
  localparam int SyncCycles  = 3;
  localparam int SetupCycles = 1;
  localparam int NumWords    = 1000;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  oclib_ready_valid_to_async_req_ack_if #(.Width(Width)) bus ();
  oclib_ready_valid_to_async_req_ack_if #(.Width(Width)) bus0 ();

  oclib_ready_valid_to_async_req_ack #(
    .Width(Width), .SyncCycles(SyncCycles), .SetupCycles(SetupCycles)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  // Second instance with no setup hold, used for the stale-ack case.
  oclib_ready_valid_to_async_req_ack #(
    .Width(Width), .SyncCycles(SyncCycles), .SetupCycles(0)
  ) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [Width-1:0] exp_q[$];
  logic [Width-1:0] rx_log[$];
  logic [Width-1:0] model_data = '0;
  bit   hs_active = 1'b0;
  bit   ack_seen  = 1'b0;
  logic req_prev  = 1'b0;
  bit   mon_on    = 1'b0;
  int   accepted  = 0;
  int   delivered = 0;

  // Monitor: inputs are driven just after posedge, so the values seen here are
  // the ones the next edge will sample.
  always @(negedge clock) begin
    if (mon_on) begin
      // The payload may only change on an accept (or be cleared by reset).
      check("out_data_hold", bus.outData, model_data);

      if (bus.outReq && !req_prev) begin
        if (exp_q.size() == 0) begin
          check("req_without_word", exp_q.size(), 1);
        end else begin
          check("delivered_word", bus.outData, exp_q.pop_front());
          rx_log.push_back(bus.outData);
          delivered++;
        end
        hs_active = 1'b1;
      end

      if (hs_active && bus.outAck) ack_seen = 1'b1;
      if (hs_active && ack_seen && !bus.outAck) begin
        hs_active = 1'b0;
        ack_seen  = 1'b0;
      end

      if (!reset) begin
        // The next edge aborts any transfer and clears the payload.
        exp_q.delete();
        model_data = '0;
        hs_active  = 1'b0;
        ack_seen   = 1'b0;
      end else if (bus.inValid && bus.inReady) begin
        // A new word may only be taken once the previous four-phase cycle has closed.
        check("accept_idle", exp_q.size() + int'(hs_active) + int'(bus.outAck), 0);
        exp_q.push_back(bus.inData);
        model_data = bus.inData;
        accepted++;
      end
      req_prev = bus.outReq;
    end
  end

  // ---------------- receiver ----------------
  bit rx_auto = 1'b0;
  bit man_ack = 1'b0;
  int rx_max  = 20;

  initial begin : receiver
    int  cnt;
    bit  auto_ack;
    cnt        = 0;
    auto_ack   = 1'b0;
    bus.outAck = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (rx_auto) begin
        if (auto_ack != bus.outReq) begin
          if (cnt > 0) begin
            cnt--;
          end else begin
            auto_ack = bus.outReq;
            cnt      = $urandom_range(rx_max, 0);
          end
        end
      end else begin
        auto_ack = 1'b0;
      end
      bus.outAck = rx_auto ? auto_ack : man_ack;
    end
  end

  // Wait until the bridge is idle with nothing outstanding; bounded.
  task automatic wait_idle(input string name, input int budget);
    int n;
    bit ok;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < budget) begin
      @(negedge clock);
      n++;
      ok = (exp_q.size() == 0) && !hs_active && !bus.outBusy && !bus.outAck && bus.inReady;
    end
    check(name, ok, 1);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin : main
    int n;
    int prev;
    int base;
    int target;
    bit ok;

    bus.inValid  = 1'b0;
    bus.inData   = '0;
    bus0.inValid = 1'b0;
    bus0.inData  = '0;
    bus0.outAck  = 1'b0;

    // Reset state.
    repeat (3) @(posedge clock);
    mon_on = 1'b1;
    @(negedge clock);
    check("rst_in_ready", bus.inReady, 0);
    check("rst_out_req", bus.outReq, 0);
    check("rst_out_data", bus.outData, 0);
    check("rst_out_busy", bus.outBusy, 0);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("first_ready", bus.inReady, 1);

    // Basic transfer of 0xA5 with a manual receiver (4-cycle ack delays).
    @(posedge clock); #1;
    bus.inValid = 1'b1;
    bus.inData  = 8'hA5;
    @(posedge clock); #1;                 // that edge was the accept edge
    bus.inValid = 1'b0;
    bus.inData  = 8'h3C;
    @(negedge clock);
    check("basic_data", bus.outData, 8'hA5);
    check("basic_req_c1", bus.outReq, 0);
    check("basic_ready_low", bus.inReady, 0);
    check("basic_busy", bus.outBusy, 1);
    @(negedge clock);
    check("basic_req_c2", bus.outReq, 1);

    // Raise ack, then count the edges after the one that first samples it
    // until outReq is seen low. That count should equal SyncCycles.
    repeat (4) @(posedge clock);
    #1 man_ack = 1'b1;
    @(posedge clock);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      ok = !bus.outReq;
    end
    check("req_fall_edges", n, SyncCycles);

    // Drop ack. The bridge re-enters IDLE SyncCycles edges after the sampling
    // edge, and inReady is high in the cycle that follows that edge.
    repeat (4) @(posedge clock);
    #1 man_ack = 1'b0;
    @(posedge clock);
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      ok = bus.inReady;
    end
    check("ready_return_edges", n, SyncCycles);
    check("basic_data_end", bus.outData, 8'hA5);

    // Back-to-back: inValid held high, each word advances only once accepted.
    rx_max  = 4;
    rx_auto = 1'b1;
    base    = rx_log.size();
    @(posedge clock); #1;
    for (int w = 1; w <= 3; w++) begin
      prev        = accepted;
      bus.inData  = w[Width-1:0];
      bus.inValid = 1'b1;
      n = 0;
      while (accepted == prev && n < 200) begin
        @(posedge clock); #1;
        n++;
      end
      check("b2b_accept", accepted - prev, 1);
    end
    bus.inValid = 1'b0;
    wait_idle("b2b_drain", 500);
    check("b2b_count", rx_log.size() - base, 3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < rx_log.size()) check("b2b_log", rx_log[base+i], i + 1);
    end
    rx_auto = 1'b0;

    // Stale ack on the SetupCycles=0 instance: request must wait for ack low.
    @(posedge clock); #1 bus0.outAck = 1'b1;
    repeat (SyncCycles + 2) @(posedge clock);
    #1;
    bus0.inValid = 1'b1;
    bus0.inData  = 8'h77;
    @(negedge clock);
    check("stale_ready", bus0.inReady, 1);
    @(posedge clock); #1 bus0.inValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      check("stale_req_low", bus0.outReq, 0);
      check("stale_busy", bus0.outBusy, 1);
    end
    @(posedge clock); #1 bus0.outAck = 1'b0;
    n = 0;
    while (!bus0.outReq && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("stale_req_rise", bus0.outReq, 1);
    check("stale_data", bus0.outData, 8'h77);
    @(posedge clock); #1 bus0.outAck = 1'b1;
    n = 0;
    while (bus0.outReq && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("stale_req_fall", bus0.outReq, 0);
    @(posedge clock); #1 bus0.outAck = 1'b0;
    n = 0;
    while (!bus0.inReady && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("stale_ready_back", bus0.inReady, 1);
    // A single word only: no second request after completion.
    repeat (6) @(negedge clock);
    check("stale_single_word", {bus0.outReq, bus0.outBusy}, 2'b00);

    // Reset in WAIT_ACK_HI aborts the transfer, then a new word goes through.
    @(posedge clock); #1;
    bus.inValid = 1'b1;
    bus.inData  = 8'h96;
    @(posedge clock); #1 bus.inValid = 1'b0;
    n = 0;
    while (!bus.outReq && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("rst_reach_req", bus.outReq, 1);
    @(posedge clock); #1 reset = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("midrst_out_req", bus.outReq, 0);
    check("midrst_out_data", bus.outData, 0);
    check("midrst_out_busy", bus.outBusy, 0);
    check("midrst_in_ready", bus.inReady, 0);
    @(posedge clock); #1 reset = 1'b1;
    @(negedge clock);
    check("midrst_ready_back", bus.inReady, 1);
    rx_max  = 6;
    rx_auto = 1'b1;
    @(posedge clock); #1;
    bus.inValid = 1'b1;
    bus.inData  = 8'h5A;
    prev = accepted;
    n = 0;
    while (accepted == prev && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    bus.inValid = 1'b0;
    wait_idle("midrst_drain", 500);
    check("midrst_word", rx_log.size() > 0 ? rx_log[rx_log.size()-1] : '1, 8'h5A);

    // Randomized producer and receiver delays 0..20.
    rx_max = 20;
    target = accepted + NumWords;
    n = 0;
    while (accepted < target && n < 70000) begin
      @(posedge clock); #1;
      n++;
      bus.inValid = ($urandom_range(3, 0) != 0);
      bus.inData  = Width'($urandom);
    end
    bus.inValid = 1'b0;
    check("random_words", accepted >= target, 1);
    wait_idle("random_drain", 300);
    check("delivered_total", delivered, accepted);
    check("queue_empty", exp_q.size(), 0);
    rx_auto = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
